// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// stage bit positions in the enable/clear vectors, and drain length.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int NSTAGE = 4;
    localparam int IFID   = 0;
    localparam int IDEX   = 1;
    localparam int EXMEM  = 2;
    localparam int MEMWB  = 3;

    // HLT sits in ID when decoded; it needs three more edges to leave WB.
    localparam int         DRAIN_CYCLES = 3;
    localparam logic [1:0] DRAIN_LOAD   = 2'(DRAIN_CYCLES - 1);

    function automatic logic [NSTAGE-1:0] stage_bit(input int idx);
        return 4'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_stall_timer.sv
// Freeze timer for multi-cycle memory accesses: holds freeze for MEM_LAT-1
// cycles from the first mem_req, then one release cycle that ignores mem_req.
module mem_stall_timer #(
    parameter int MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic mem_req,
    output logic freeze
);

    localparam int            CW   = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LOAD = (MEM_LAT > 2) ? CW'(MEM_LAT - 2) : '0;

    // rem counts freeze cycles still owed after the current one.
    logic [CW-1:0] rem;
    logic          rel_q;
    logic          trigger;

    assign trigger = (MEM_LAT > 1) && arm && mem_req && (rem == '0) && !rel_q;
    assign freeze  = trigger || (rem != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            rel_q <= 1'b0;
        end else if (trigger) begin
            rem   <= LOAD;
            rel_q <= (LOAD == '0);
        end else if (rem != '0) begin
            rem   <= rem - 1'b1;
            rel_q <= (rem == CW'(1));
        end else begin
            rel_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register sequencing: merges memory freeze, mispredict flush,
// load-use stall and HLT drain into per-stage enables/clears (combinational).
// Optional statistics counters under PIPE_CTRL_STATS_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_use,
    input  logic              mispredict,
    input  logic              mem_req,
    input  logic              halt_req,
    output logic              pc_ena,
    output logic [NSTAGE-1:0] stage_ena,
    output logic [NSTAGE-1:0] stage_clrn,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t     state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic       freeze;
    logic       arm;

    assign arm = (state_q != ST_HALTED);

    mem_stall_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .mem_req (mem_req),
        .freeze  (freeze)
    );

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_ena     = 1'b0;
        stage_ena  = '0;
        stage_clrn = '0;
        halted     = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
            drain_d = '0;
        end else if (state_q == ST_HALTED) begin
            stage_clrn = '1;
            halted     = 1'b1;
        end else begin
            pc_ena     = 1'b1;
            stage_ena  = '1;
            stage_clrn = '1;
            if (freeze) begin
                // Hold everything up to MEM; push a bubble into WB.
                pc_ena     = 1'b0;
                stage_ena  = stage_bit(MEMWB);
                stage_clrn = ~stage_bit(MEMWB);
            end else if (state_q == ST_DRAIN) begin
                pc_ena           = 1'b0;
                stage_clrn[IFID] = 1'b0;
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end else if (mispredict) begin
                stage_clrn[IFID] = 1'b0;
                stage_clrn[IDEX] = 1'b0;
            end else if (halt_req) begin
                // HLT does not read registers, so it takes precedence over load-use.
                pc_ena           = 1'b0;
                stage_clrn[IFID] = 1'b0;
                state_d          = ST_DRAIN;
                drain_d          = DRAIN_LOAD;
            end else if (load_use) begin
                pc_ena           = 1'b0;
                stage_ena[IFID]  = 1'b0;
                stage_clrn[IDEX] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             flush;

    assign flush = !rst && (state_q == ST_RUN) && !freeze && mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_ena && (state_q != ST_HALTED) && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (MEM_LAT=4 and 3) share random stimulus
// and are compared every cycle against a cycle-count model, plus literal checks.
module tb_pipe_ctrl;

    localparam int MAXC = 65535;

    logic clk;
    logic rst, load_use, mispredict, mem_req, halt_req;
    logic        pc   [2];
    logic [3:0]  ena  [2];
    logic [3:0]  clrn [2];
    logic        hl   [2];
    logic [15:0] sc   [2];
    logic [15:0] fc   [2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model: remaining freeze cycles, release flag, drain cycles left, halted.
    int lat    [2] = '{4, 3};
    int frz    [2];
    bit rel    [2];
    bit mdrain [2];
    int dleft  [2];
    bit mhalt  [2];
    int mstall [2];
    int mflush [2];

    pipe_ctrl #(.MEM_LAT(4), .CNT_W(16)) u_lat4 (
        .clk(clk), .rst(rst), .load_use(load_use), .mispredict(mispredict),
        .mem_req(mem_req), .halt_req(halt_req), .pc_ena(pc[0]),
        .stage_ena(ena[0]), .stage_clrn(clrn[0]), .halted(hl[0]),
        .stall_cnt(sc[0]), .flush_cnt(fc[0])
    );

    pipe_ctrl #(.MEM_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .load_use(load_use), .mispredict(mispredict),
        .mem_req(mem_req), .halt_req(halt_req), .pc_ena(pc[1]),
        .stage_ena(ena[1]), .stage_clrn(clrn[1]), .halted(hl[1]),
        .stall_cnt(sc[1]), .flush_cnt(fc[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit frozen_now(input int i);
        return (frz[i] > 0) || (!rel[i] && mem_req && lat[i] > 1);
    endfunction

    function automatic void expect_out(input int i, output logic p, output logic [3:0] e,
                                       output logic [3:0] c, output logic h, output bit fl);
        p = 0; e = 4'b0000; c = 4'b0000; h = 0; fl = 0;
        if (rst) return;
        if (mhalt[i]) begin
            c = 4'b1111; h = 1;
            return;
        end
        p = 1; e = 4'b1111; c = 4'b1111;
        if (frozen_now(i)) begin
            p = 0; e = 4'b1000; c = 4'b0111;
        end else if (mdrain[i]) begin
            p = 0; c = 4'b1110;
        end else if (mispredict) begin
            c = 4'b1100; fl = 1;
        end else if (halt_req) begin
            p = 0; c = 4'b1110;
        end else if (load_use) begin
            p = 0; e = 4'b1110; c = 4'b1101;
        end
    endfunction

    task automatic model_update();
        logic p, h; logic [3:0] e, c; bit fl, fz;
        for (int i = 0; i < 2; i++) begin
            expect_out(i, p, e, c, h, fl);
            if (rst) begin
                frz[i] = 0; rel[i] = 0; mdrain[i] = 0; dleft[i] = 0;
                mhalt[i] = 0; mstall[i] = 0; mflush[i] = 0;
            end else if (!mhalt[i]) begin
                fz = frozen_now(i);
                if (!p && mstall[i] < MAXC) mstall[i]++;
                if (fl && mflush[i] < MAXC) mflush[i]++;
                if (frz[i] > 0) begin
                    frz[i]--;
                    rel[i] = (frz[i] == 0);
                end else if (fz) begin
                    frz[i] = lat[i] - 2;
                    rel[i] = (lat[i] == 2);
                end else begin
                    rel[i] = 0;
                end
                if (!fz) begin
                    if (mdrain[i]) begin
                        dleft[i]--;
                        if (dleft[i] == 0) begin
                            mdrain[i] = 0; mhalt[i] = 1;
                        end
                    end else if (!mispredict && halt_req) begin
                        mdrain[i] = 1; dleft[i] = 3;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t got=%0h expected=%0h", nm, i, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        logic p, h; logic [3:0] e, c; bit fl;
        logic [15:0] es, ef;
        for (int i = 0; i < 2; i++) begin
            expect_out(i, p, e, c, h, fl);
`ifdef PIPE_CTRL_STATS_EN
            es = 16'(mstall[i]); ef = 16'(mflush[i]);
`else
            es = 16'd0; ef = 16'd0;
`endif
            chk("pc_ena", i, 32'(pc[i]), 32'(p));
            chk("stage_ena", i, 32'(ena[i]), 32'(e));
            chk("stage_clrn", i, 32'(clrn[i]), 32'(c));
            chk("halted", i, 32'(hl[i]), 32'(h));
            chk("stall_cnt", i, 32'(sc[i]), 32'(es));
            chk("flush_cnt", i, 32'(fc[i]), 32'(ef));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare_all();
        end
    end

    task automatic drive(input bit r, input bit lu, input bit mp, input bit mr, input bit hr);
        @(posedge clk);
        model_update();
        #1;
        rst = r; load_use = lu; mispredict = mp; mem_req = mr; halt_req = hr;
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int i, input logic p, input logic [3:0] e,
                       input logic [3:0] c, input logic h);
        chk({nm, ".pc"}, i, 32'(pc[i]), 32'(p));
        chk({nm, ".ena"}, i, 32'(ena[i]), 32'(e));
        chk({nm, ".clrn"}, i, 32'(clrn[i]), 32'(c));
        chk({nm, ".halted"}, i, 32'(hl[i]), 32'(h));
    endtask

    initial begin
        rst = 1; load_use = 0; mispredict = 0; mem_req = 0; halt_req = 0;
        for (int i = 0; i < 2; i++) begin
            frz[i] = 0; rel[i] = 0; mdrain[i] = 0; dleft[i] = 0;
            mhalt[i] = 0; mstall[i] = 0; mflush[i] = 0;
        end
        chk_en = 1;

        // Reset held two cycles, then first run cycle.
        drive(1, 0, 0, 0, 0); lit("rst0", 0, 0, 4'h0, 4'h0, 0); lit("rst0", 1, 0, 4'h0, 4'h0, 0);
        drive(1, 0, 0, 0, 0); lit("rst1", 0, 0, 4'h0, 4'h0, 0);
        drive(0, 0, 0, 0, 0); lit("run0", 0, 1, 4'hF, 4'hF, 0); lit("run0", 1, 1, 4'hF, 4'hF, 0);

        // mem_req for 4 cycles on MEM_LAT=4: three freeze cycles, fourth normal.
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 0);
            if (k < 3) lit("freeze", 0, 0, 4'h8, 4'h7, 0);
            else       lit("release", 0, 1, 4'hF, 4'hF, 0);
        end
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0);

        // Mispredict beats load-use.
        drive(0, 1, 1, 0, 0); lit("mp_lu", 0, 1, 4'hF, 4'hC, 0); lit("mp_lu", 1, 1, 4'hF, 4'hC, 0);

        // Plain halt: drain three cycles, halted on the fourth.
        drive(0, 0, 0, 0, 1); lit("halt_t", 0, 0, 4'hF, 4'hE, 0);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 0, 0, 0); lit("drain", 0, 0, 4'hF, 4'hE, 0);
        end
        drive(0, 0, 0, 0, 0); lit("halted", 0, 0, 4'h0, 4'hF, 1); lit("halted", 1, 0, 4'h0, 4'hF, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, k[0], !k[0], 1, 1); lit("halt_hold", 0, 0, 4'h0, 4'hF, 1);
        end

        // Halt then memory op on MEM_LAT=3: halted rises at t+6.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0); lit("hm_frz1", 1, 0, 4'h8, 4'h7, 0);
        drive(0, 0, 0, 0, 0); lit("hm_frz2", 1, 0, 4'h8, 4'h7, 0);
        for (int k = 3; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0); lit("hm_drain", 1, 0, 4'hF, 4'hE, 0);
        end
        drive(0, 0, 0, 0, 0); lit("hm_halt", 1, 0, 4'h0, 4'hF, 1);

        // Reset during the second freeze cycle, then a fresh full freeze.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0); lit("rf_frz1", 0, 0, 4'h8, 4'h7, 0);
        drive(1, 0, 0, 1, 0); lit("rf_rst", 0, 0, 4'h0, 4'h0, 0);
        drive(0, 0, 0, 0, 0); lit("rf_run", 0, 1, 4'hF, 4'hF, 0);
        chk("rf_stall0", 0, 32'(sc[0]), 32'd0);
        chk("rf_stall0", 1, 32'(sc[1]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 0); lit("rf_fresh", 0, 0, 4'h8, 4'h7, 0);
        end
        drive(0, 0, 0, 0, 0); lit("rf_done", 0, 1, 4'hF, 4'hF, 0);

        // Random traffic checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 39) == 0);
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Sequencing controller for the 2-wide pipeline's flip-flop pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC.
- Each register bank uses per-bit enable and active-low synchronous clear. This block drives those per stage.
- Resolves load-use stalls, branch-mispredict flushes, multi-cycle memory freezes and HLT drain into one consistent set of enables and clears.

Parameters:
- MEM_LAT, 4, memory access latency in cycles; values ≥1; 1 means a memory access never stalls.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- load_use  in  1  ID-stage load-use hazard detected
- mispredict  in  1  EX-stage branch resolved mispredicted
- mem_req  in  1  MEM stage holds a load/store
- halt_req  in  1  HLT decoded in ID
- pc_ena  out  1  PC register enable
- stage_ena  out  4  enable per stage; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB
- stage_clrn  out  4  active-low clear per stage, same bit order
- halted  out  1  pipeline halted
- stall_cnt  out  CNT_W  cycles with pc_ena=0 outside HALTED (feature only)
- flush_cnt  out  CNT_W  mispredict flushes taken (feature only)

Behaviour:
- Outputs are combinational from state and inputs, so a stall or flush takes effect in the same cycle. Next state registers on clk.
- rst (overrides all, same cycle): pc_ena=0, stage_ena=0000, stage_clrn=0000, halted=0. Next state is RUN; memory counter and flags are zeroed.
- Default in RUN: pc_ena=1, stage_ena=1111, stage_clrn=1111.
- Per-cycle priority: rst > memory freeze > mispredict > halt_req / load_use.
- Memory freeze:
  - Triggers in RUN or DRAIN when mem_req=1, MEM_LAT>1 and no freeze/release is active.
  - Lasts exactly MEM_LAT-1 consecutive cycles, starting with the first cycle mem_req is seen.
  - During freeze: pc_ena=0, stage_ena[2:0]=000, stage_ena[3]=1, stage_clrn[3]=0 (bubble into WB).
  - The cycle after the freeze is the release cycle. Outputs are normal and mem_req is ignored, because it is the same instruction leaving MEM.
  - mispredict, halt_req and load_use are ignored while frozen. They re-present because their stages are held.
  - The DRAIN countdown does not advance while frozen.
- Mispredict (RUN): stage_clrn[1:0]=00, pc_ena=1. This flushes the younger IF/ID and ID/EX contents and also cancels a coincident halt_req or load_use.
- Load-use (RUN, no mispredict): pc_ena=0, stage_ena[0]=0, stage_clrn[1]=0 (bubble into EX).
- halt_req (RUN, no mispredict):
  - Same cycle: pc_ena=0, stage_clrn[0]=0.
  - Enter DRAIN with drain count 2.
- DRAIN:
  - Every cycle: pc_ena=0, stage_clrn[0]=0, other bits default.
  - The count decrements each unfrozen cycle.
  - On an unfrozen cycle with count 0, go to HALTED next. HLT has then retired from WB.
  - mispredict and load_use are ignored in DRAIN (only older instructions remain).
- HALTED:
  - pc_ena=0, stage_ena=0000, stage_clrn=1111, halted=1. All inputs are ignored.
  - Exit only by rst.
- Freeze counter: loaded with MEM_LAT-2 on trigger. Freeze ends on the cycle it reads 0. No wrap.

Optional Feature:
- PIPE_CTRL_STATS_EN defined:
  - stall_cnt increments each cycle with pc_ena=0 while not in HALTED and not in rst.
  - flush_cnt increments each cycle a mispredict flush is applied.
  - Both saturate at all-ones and clear on rst.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter logic is synthesised. Ports are present either way.

Decomposition:
- pipe_ctrl_pkg holds:
  - state encoding RUN/DRAIN/HALTED
  - stage bit indices IFID=0, IDEX=1, EXMEM=2, MEMWB=3
  - DRAIN_CYCLES=3
- One sub-module, mem_stall_timer: owns the freeze trigger, countdown and release flag, and outputs freeze.

Test Plan:
- rst held 2 cycles, then released → during rst stage_clrn=0000, pc_ena=0; the first cycle after rst gives pc_ena=1, stage_ena=1111, stage_clrn=1111.
- MEM_LAT=4, mem_req high for 4 cycles → freeze for exactly cycles 1-3 (stage_ena=1000, stage_clrn=0111); cycle 4 is normal; no re-trigger.
- mispredict=1 and load_use=1 in the same cycle → stage_clrn=1100, pc_ena=1, stage_ena=1111.
- halt_req pulse at cycle t with no memory ops → DRAIN for t+1..t+3; halted=1 from t+4; stage_ena=0000 thereafter, despite mispredict/load_use toggling.
- halt_req at t, mem_req at t+1 with MEM_LAT=3 → 2 freeze cycles; halted rises at t+6.
- rst asserted during the second freeze cycle → RUN next; a subsequent mem_req triggers a full fresh MEM_LAT-1 freeze. With PIPE_CTRL_STATS_EN defined, stall_cnt reads 0 after rst.
